// File: rtl/out_link_stage_rr_pkg.sv
// noc_out_pkg: shared constants and helpers for the router output link stage.
//
// Contents:
//   DEFAULT_DATA_W  - default packet width in bits
//   src_w(n)        - width of an index into n items, never less than 1 bit
//   entry_w(d, n)   - width of a packed staging entry {src, data}
//
// Each user builds its own stage_entry_t struct from src_w() and DATA_W,
// because a package cannot hold a parameterised typedef.
package noc_out_pkg;

    localparam int DEFAULT_DATA_W = 64;

    function automatic int src_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int entry_w(input int data_w, input int num_src);
        return data_w + src_w(num_src);
    endfunction

endpackage

// File: rtl/out_link_stage_rr_if.sv
// out_link_stage_rr_if: handshake bundle between the upstream output FIFOs,
// the link stage and the downstream link.
//
// Signals:
//   empty      per-source FIFO empty flag (FIFO -> stage)
//   in_packet  per-source FIFO head data, source i at [i*DATA_W +: DATA_W]
//   read_en    per-source pop strobe, at most one bit high (stage -> FIFO)
//   ro         downstream ready (link -> stage)
//   so         packet sent this cycle (stage -> link)
//   out_packet head-of-buffer packet
//   out_src    source index of the head packet
//   occupancy  number of staged entries
//
// Handshake: upstream pops happen on every edge where read_en[i]=1 (the FIFO
// is first-word-fall-through, so in_packet is already valid when empty=0).
// Downstream transfers happen on every edge where so=1; so already includes
// ro, so the link just consumes whenever so is high.
//
// Modports: slave = the stage, master = whatever drives the stage.
interface out_link_stage_rr_if
    import noc_out_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int NUM_SRC     = 2,
    parameter int STAGE_DEPTH = 2
) ();

    localparam int SRC_W = src_w(NUM_SRC);
    localparam int OCC_W = $clog2(STAGE_DEPTH + 1);

    logic [NUM_SRC-1:0]        empty;
    logic [NUM_SRC*DATA_W-1:0] in_packet;
    logic [NUM_SRC-1:0]        read_en;
    logic                      ro;
    logic                      so;
    logic [DATA_W-1:0]         out_packet;
    logic [SRC_W-1:0]          out_src;
    logic [OCC_W-1:0]          occupancy;

    modport slave (
        input  empty, in_packet, ro,
        output read_en, so, out_packet, out_src, occupancy
    );

    modport master (
        output empty, in_packet, ro,
        input  read_en, so, out_packet, out_src, occupancy
    );

endinterface

// File: rtl/out_link_stage_rr_arbiter.sv
// rr_arbiter: round-robin arbiter over N requesters.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset (pointer -> 0)
//   req         request vector
//   advance     a grant was consumed this cycle; move the pointer past it
//   grant       one-hot grant (all zero when no request)
//   grant_idx   index of the granted requester
//
// The search starts at the pointer and wraps modulo N. After a consumed
// grant g the pointer becomes (g+1) mod N; it holds when nothing is consumed.
module rr_arbiter
    import noc_out_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic                  advance,
    output logic [N-1:0]          grant,
    output logic [src_w(N)-1:0]   grant_idx
);

    localparam int IW = src_w(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          found;

    // Candidates are visited in priority order; the inner loop compares
    // against constant indices so no variable bit-select is needed.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            for (int j = 0; j < N; j++) begin
                if (!found && (cand == IW'(j)) && req[j]) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/out_link_stage_rr.sv
// out_link_stage_rr: router output link stage. Drains NUM_SRC FWFT output
// FIFOs through a round-robin arbiter into a STAGE_DEPTH-entry circular
// staging buffer and presents the head entry to the downstream link.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; discards staged packets
//   link       out_link_stage_rr_if.slave (empty/in_packet/read_en upstream,
//              ro/so/out_packet/out_src/occupancy downstream)
//   sent_cnt   (OUT_LINK_STATS_EN only) packets sent, wraps at 2^32
//   stall_cnt  (OUT_LINK_STATS_EN only) cycles holding data with ro=0
//
// Optional macro: OUT_LINK_STATS_EN adds the two statistics counters.
//
// Parameters must match those of the connected interface instance.
// STAGE_DEPTH=1 with NUM_SRC=1 gives one packet every two cycles (no pop
// while the single entry is occupied); STAGE_DEPTH>=2 sustains one per cycle.
module out_link_stage_rr
    import noc_out_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int NUM_SRC     = 2,
    parameter int STAGE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    out_link_stage_rr_if.slave     link
`ifdef OUT_LINK_STATS_EN
    ,
    output logic [31:0]            sent_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int SRC_W = src_w(NUM_SRC);
    localparam int PTR_W = src_w(STAGE_DEPTH);
    localparam int OCC_W = $clog2(STAGE_DEPTH + 1);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } stage_entry_t;

    stage_entry_t      mem [STAGE_DEPTH];
    stage_entry_t      head_entry;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [OCC_W-1:0]  count;

    logic              space;
    logic              push;
    logic              pop;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic [SRC_W-1:0]  grant_idx;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(STAGE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // No pass-through when full: space looks only at the registered count,
    // so a same-cycle send does not open a slot for a pop.
    assign space = (count < OCC_W'(STAGE_DEPTH));
    assign req   = ~link.empty;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .advance   (push),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign link.read_en = (space && !reset) ? grant : '0;
    assign push         = |link.read_en;
    assign pop          = (count != '0) && link.ro && !reset;
    assign link.so      = pop;

    // Head and source muxes use constant-index compares so odd depths and
    // single-entry configurations need no special casing.
    always_comb begin
        sel_data = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (grant_idx == SRC_W'(s)) begin
                sel_data = link.in_packet[s*DATA_W +: DATA_W];
            end
        end
        head_entry = mem[0];
        for (int i = 0; i < STAGE_DEPTH; i++) begin
            if (head == PTR_W'(i)) begin
                head_entry = mem[i];
            end
        end
    end

    // Outputs read zero while reset is held, even before the first reset edge.
    assign link.out_packet = reset ? '0 : head_entry.data;
    assign link.out_src    = reset ? '0 : head_entry.src;
    assign link.occupancy  = reset ? '0 : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < STAGE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGE_DEPTH; i++) begin
                if (push && (tail == PTR_W'(i))) begin
                    mem[i] <= '{src: grant_idx, data: sel_data};
                end
            end
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef OUT_LINK_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) sent_cnt <= sent_cnt + 32'd1;
            if ((count != '0) && !link.ro) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_out_link_stage_rr.sv
// Bench for out_link_stage_rr: a 2-source/2-deep instance (ifa/dut) and a
// 1-source/1-deep legacy instance (ifb/dut1). FIFO contents are modelled as
// queues; a reference model predicts read_en, so and occupancy each cycle
// and a scoreboard queue holds the expected {src, data} stream.
module tb_out_link_stage_rr;
    import noc_out_pkg::*;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    out_link_stage_rr_if #(.DATA_W(DW), .NUM_SRC(2), .STAGE_DEPTH(2)) ifa();
    out_link_stage_rr_if #(.DATA_W(DW), .NUM_SRC(1), .STAGE_DEPTH(1)) ifb();

`ifdef OUT_LINK_STATS_EN
    logic [31:0] sent_a, stall_a, sent_b, stall_b;
`endif

    out_link_stage_rr #(.DATA_W(DW), .NUM_SRC(2), .STAGE_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .link      (ifa.slave)
`ifdef OUT_LINK_STATS_EN
        ,
        .sent_cnt  (sent_a),
        .stall_cnt (stall_a)
`endif
    );

    out_link_stage_rr #(.DATA_W(DW), .NUM_SRC(1), .STAGE_DEPTH(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .link      (ifb.slave)
`ifdef OUT_LINK_STATS_EN
        ,
        .sent_cnt  (sent_b),
        .stall_cnt (stall_b)
`endif
    );

    // FIFO models and scoreboard queues
    logic [DW-1:0] fq0[$];
    logic [DW-1:0] fq1[$];
    logic [DW-1:0] fqb[$];
    logic [DW:0]   exp_q[$];   // {src, data}
    logic [DW-1:0] expb_q[$];

    int          rr_m = 0;
    logic [1:0]  rd_m = '0;
    logic        rdb_m = 1'b0;
    logic [31:0] exp_sent_a = '0, exp_stall_a = '0;
    logic [31:0] exp_sent_b = '0, exp_stall_b = '0;
    int          dut_sent_a = 0, dut_sent_b = 0;
    int          errors = 0, checks = 0;
    int          base;

    task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        ifa.empty[0] = (fq0.size() == 0);
        ifa.empty[1] = (fq1.size() == 0);
        ifa.in_packet[DW-1:0]    = (fq0.size() != 0) ? fq0[0] : '0;
        ifa.in_packet[2*DW-1:DW] = (fq1.size() != 0) ? fq1[0] : '0;
        ifb.empty[0] = (fqb.size() == 0);
        ifb.in_packet = (fqb.size() != 0) ? fqb[0] : '0;
    endtask

    // Called on the falling edge: compare DUT outputs against the model for
    // this cycle and queue the entries that will be captured at the next edge.
    task automatic monitor();
        logic [DW:0]   e;
        logic [DW-1:0] eb;
        logic          so_m, stall_m;
        int            s;
        if (ifa.so === 1'b1) dut_sent_a++;
        if (ifb.so === 1'b1) dut_sent_b++;
        if (reset) begin
            rd_m  = '0;
            rdb_m = 1'b0;
            check("a_read_en_rst", ifa.read_en, '0);
            check("a_so_rst", ifa.so, '0);
            check("a_occ_rst", ifa.occupancy, '0);
            check("a_out_packet_rst", ifa.out_packet, '0);
            check("b_so_rst", ifb.so, '0);
            check("b_read_en_rst", ifb.read_en, '0);
        end else begin
            // dut (2 sources, depth 2)
            rd_m = '0;
            if (exp_q.size() < 2) begin
                for (int i = 0; i < 2; i++) begin
                    s = (rr_m + i) % 2;
                    if (rd_m == '0 && ((s == 0) ? (fq0.size() != 0) : (fq1.size() != 0)))
                        rd_m = (s == 0) ? 2'b01 : 2'b10;
                end
            end
            so_m    = (exp_q.size() != 0) && ifa.ro;
            stall_m = (exp_q.size() != 0) && !ifa.ro;
            check("a_read_en", ifa.read_en, rd_m);
            check("a_so", ifa.so, so_m);
            check("a_occupancy", ifa.occupancy, exp_q.size());
`ifdef OUT_LINK_STATS_EN
            check("a_sent_cnt", sent_a, exp_sent_a);
            check("a_stall_cnt", stall_a, exp_stall_a);
`endif
            if (so_m) begin
                e = exp_q.pop_front();
                check("a_out_packet", ifa.out_packet, e[DW-1:0]);
                check("a_out_src", ifa.out_src, e[DW]);
                exp_sent_a++;
            end
            if (stall_m) exp_stall_a++;
            if (rd_m[0]) exp_q.push_back({1'b0, fq0[0]});
            if (rd_m[1]) exp_q.push_back({1'b1, fq1[0]});

            // dut1 (1 source, depth 1)
            rdb_m   = (expb_q.size() == 0) && (fqb.size() != 0);
            so_m    = (expb_q.size() != 0) && ifb.ro;
            stall_m = (expb_q.size() != 0) && !ifb.ro;
            check("b_read_en", ifb.read_en, rdb_m);
            check("b_so", ifb.so, so_m);
`ifdef OUT_LINK_STATS_EN
            check("b_sent_cnt", sent_b, exp_sent_b);
            check("b_stall_cnt", stall_b, exp_stall_b);
`endif
            if (so_m) begin
                eb = expb_q.pop_front();
                check("b_out_packet", ifb.out_packet, eb);
                check("b_out_src", ifb.out_src, '0);
                exp_sent_b++;
            end
            if (stall_m) exp_stall_b++;
            if (rdb_m) expb_q.push_back(fqb[0]);
        end
    endtask

    // Applies the model's view of the clock edge just taken.
    task automatic commit(input logic rst_s);
        if (rst_s) begin
            exp_q.delete();
            expb_q.delete();
            rr_m        = 0;
            exp_sent_a  = '0;
            exp_stall_a = '0;
            exp_sent_b  = '0;
            exp_stall_b = '0;
        end else begin
            if (rd_m[0]) begin fq0.delete(0); rr_m = 1; end
            if (rd_m[1]) begin fq1.delete(0); rr_m = 0; end
            if (rdb_m) fqb.delete(0);
        end
    endtask

    task automatic tick();
        logic rst_s;
        @(negedge clk);
        rst_s = reset;
        monitor();
        @(posedge clk);
        #1;
        commit(rst_s);
        drive_inputs();
        #1;
    endtask

    initial begin
        logic [1:0] rr_seq [4];
        rr_seq = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset / idle with both sources holding data
        reset = 1'b1;
        ifa.ro = 1'b1;
        ifb.ro = 1'b1;
        fq0 = '{64'h10, 64'h11};
        fq1 = '{64'h20, 64'h21};
        drive_inputs();
        tick();
        tick();
        check("rst_read_en", ifa.read_en, '0);
        check("rst_so", ifa.so, '0);
        check("rst_occupancy", ifa.occupancy, '0);
        check("rst_out_packet", ifa.out_packet, '0);
        check("rst_out_src", ifa.out_src, '0);

        // Round-robin: src0, src1, src0, src1 -> 0x10, 0x20, 0x11, 0x21
        reset = 1'b0;
        #1;
        base = dut_sent_a;
        for (int k = 0; k < 4; k++) begin
            check("rr_grant", ifa.read_en, rr_seq[k]);
            tick();
        end
        check("rr_idle_read_en", ifa.read_en, '0);
        tick();
        tick();
        check("rr_sent_count", dut_sent_a - base, 4);

        // Throughput: one pop and one send per cycle
        fq0 = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
        drive_inputs();
        #1;
        base = dut_sent_a;
        for (int k = 0; k < 4; k++) begin
            check("tp_read_en", ifa.read_en, 2'b01);
            check("tp_so", ifa.so, (k >= 1));
            tick();
        end
        check("tp_last_so", ifa.so, 1'b1);
        check("tp_last_packet", ifa.out_packet, 64'hA4);
        tick();
        check("tp_sent_count", dut_sent_a - base, 4);

        // Backpressure: fill with ro=0, then release
        ifa.ro = 1'b0;
        fq0 = '{64'hB1, 64'hB2, 64'hB3};
        drive_inputs();
        #1;
        base = dut_sent_a;
        check("bp_read_en0", ifa.read_en, 2'b01);
        tick();
        check("bp_read_en1", ifa.read_en, 2'b01);
        check("bp_occ1", ifa.occupancy, 1);
        tick();
        check("bp_full_read_en", ifa.read_en, '0);
        check("bp_full_occ", ifa.occupancy, 2);
        check("bp_full_so", ifa.so, '0);
        tick();
        check("bp_hold_occ", ifa.occupancy, 2);
        ifa.ro = 1'b1;
        #1;
        check("bp_release_so", ifa.so, 1'b1);
        check("bp_release_packet", ifa.out_packet, 64'hB1);
        check("bp_release_read_en", ifa.read_en, '0);
        tick();
        check("bp_resume_read_en", ifa.read_en, 2'b01);
        tick();
        tick();
        tick();
        check("bp_sent_count", dut_sent_a - base, 3);

        // Legacy timing on the 1x1 instance: pops and sends alternate
        fqb = '{64'hC1, 64'hC2, 64'hC3};
        drive_inputs();
        #1;
        base = dut_sent_b;
        for (int k = 0; k < 6; k++) begin
            check("legacy_read_en", ifb.read_en, (k % 2 == 0));
            check("legacy_so", ifb.so, (k % 2 == 1));
            tick();
        end
        check("legacy_sent_count", dut_sent_b - base, 3);

        // Reset mid-operation discards staged packets
        ifa.ro = 1'b0;
        fq0 = '{64'hE1, 64'hE2, 64'hE3};
        drive_inputs();
        #1;
        tick();
        tick();
        check("mid_occ_full", ifa.occupancy, 2);
`ifdef OUT_LINK_STATS_EN
        check("mid_sent_before", sent_a, exp_sent_a);
`endif
        reset = 1'b1;
        #1;
        check("mid_rst_so", ifa.so, '0);
        check("mid_rst_occ", ifa.occupancy, '0);
        check("mid_rst_read_en", ifa.read_en, '0);
        check("mid_rst_out_packet", ifa.out_packet, '0);
        tick();
        reset = 1'b0;
        ifa.ro = 1'b1;
        fq0.delete();
        drive_inputs();
        #1;
        base = dut_sent_a;
        check("mid_after_occ", ifa.occupancy, '0);
        check("mid_after_so", ifa.so, '0);
`ifdef OUT_LINK_STATS_EN
        check("mid_after_sent_cnt", sent_a, 32'd0);
        check("mid_after_stall_cnt", stall_a, 32'd0);
`endif
        tick();
        tick();
        tick();
        check("mid_no_stale_sends", dut_sent_a - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/out_link_stage_rr.md
Name: out_link_stage_rr

Overview:
- Parametrised successor of the single-register router output handshake stage.
- Drains NUM_SRC first-word-fall-through output FIFOs (e.g. per-virtual-channel queues) via round-robin arbitration into a STAGE_DEPTH-entry circular staging buffer.
- Presents packets to the downstream link with the so/ro handshake.
- STAGE_DEPTH=1, NUM_SRC=1 reproduces previous-generation timing (one packet per two cycles); STAGE_DEPTH>=2 sustains one packet per cycle.

Parameters:
- DATA_W, 64, packet width in bits.
- NUM_SRC, 2, number of upstream FIFOs (1..8).
- STAGE_DEPTH, 2, staging buffer entries (1..8).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- empty  in  NUM_SRC  per-source FIFO empty flag.
- in_packet  in  NUM_SRC*DATA_W  per-source FIFO head data; source i at bits [i*DATA_W +: DATA_W]; valid whenever empty[i]=0.
- read_en  out  NUM_SRC  per-source pop strobe; at most one bit high.
- ro  in  1  downstream ready.
- so  out  1  packet valid/sent this cycle.
- out_packet  out  DATA_W  head-of-buffer packet.
- out_src  out  $clog2(NUM_SRC) (min 1)  source index of head packet.
- occupancy  out  $clog2(STAGE_DEPTH+1)  entries held.

Behaviour:
- Reset: all storage entries, head/tail pointers, count and RR pointer (to 0) cleared. Outputs during and after reset: read_en=0, so=0, out_packet=0, out_src=0, occupancy=0. Reset mid-operation discards staged packets. read_en is gated by reset combinationally.
- Space: space = (count < STAGE_DEPTH). No same-cycle pass-through when full.
- Pop request: read_en[g]=1 combinationally when space=1 and g is the RR winner among sources with empty=0.
- Arbitration order: search begins at rr_ptr and wraps modulo NUM_SRC.
- RR pointer update: after a pop from g, rr_ptr <= (g+1) mod NUM_SRC. It is unchanged when nothing pops.
- Capture: on the same clock edge as the pop, {g, in_packet[g]} is written at tail and tail advances (wrap at STAGE_DEPTH-1 -> 0).
- Send: so = (count != 0) && ro, combinational from ro. out_packet and out_src equal the entry at head. On so, head advances with the same wrap rule.
- Latency: a packet popped at edge N is presentable (so may assert) in the cycle after edge N. ro=1 continuously gives 1-cycle stage latency.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full buffer: read_en=0 regardless of empty. so may still drain; a pop resumes the following cycle.
- Empty buffer: so=0 regardless of ro. out_packet/out_src show stale head contents; checked only when so=1, except the post-reset value of 0.
- A source whose empty flag rises before being granted is skipped. No request latching.
- Ordering: order is preserved per source. Cross-source order follows grant order.

Optional Feature:
- Macro OUT_LINK_STATS_EN.
- When defined:
  - Extra output ports sent_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - sent_cnt increments on every so=1 cycle.
  - stall_cnt increments every cycle with count!=0 && ro=0.
  - Both counters wrap from 0xFFFFFFFF to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package noc_out_pkg holds:
  - Constant DEFAULT_DATA_W=64.
  - Function src_w(n) returning max(1,$clog2(n)).
  - Parameterised struct typedef stage_entry_t {src, data}, or equivalent packed layout constants.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], advance.
  - Outputs: one-hot grant, grant_idx.
  - Internal pointer register with synchronous active-high reset.
  - Instantiated once, with req = ~empty and advance = |read_en.

Test Plan:
- Reset/idle: reset=1 for 2 cycles with empty=2'b00 -> read_en=0, so=0, occupancy=0, out_packet=0; after release, read_en=2'b01 in the first cycle.
- Throughput: DEPTH=2, src0 holds 0xA1..0xA4, src1 empty, ro=1 -> read_en[0] every cycle; so every cycle from the second cycle on; packets emerge A1,A2,A3,A4 with out_src=0.
- Round-robin: both sources non-empty (src0 0x10,0x11; src1 0x20,0x21), ro=1 -> pop order src0,src1,src0,src1; output 0x10,0x20,0x11,0x21.
- Backpressure/full: DEPTH=2, ro=0 with src0 non-empty -> two pops, then read_en=0, occupancy=2, so=0. Raise ro -> so=1 with the oldest packet; read_en resumes the next cycle.
- Legacy timing: NUM_SRC=1, DEPTH=1, ro=1, FIFO holding 3 packets -> read_en and so alternate cycles; 3 packets sent in 6 cycles.
- Reset mid-operation with stats: occupancy=2, sent_cnt=5; assert reset one cycle -> occupancy=0, so=0, sent_cnt=0, staged packets never appear on out_packet with so=1.
